// File: rtl/axis_skid_slice_pkg.sv
// Shared state encoding and next-state rule for the CBS stream register slices.
package axis_skid_slice_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   typedef enum logic [1:0] {
      S_EMPTY = ST_EMPTY,
      S_BUSY  = ST_BUSY,
      S_FULL  = ST_FULL
   } slice_state_e;

   // Occupancy rule: the output register fills first, the skid register only absorbs overflow.
   function automatic slice_state_e slice_next_state(input slice_state_e st,
                                                     input logic in_beat,
                                                     input logic out_beat);
      slice_state_e nxt;
      nxt = st;
      case (st)
         S_EMPTY: if (in_beat) nxt = S_BUSY;
         S_BUSY: begin
            if (in_beat && !out_beat)      nxt = S_FULL;
            else if (!in_beat && out_beat) nxt = S_EMPTY;
         end
         S_FULL:  if (out_beat) nxt = S_BUSY;
         default: nxt = S_EMPTY;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// Full valid/ready register slice with a 2-entry skid buffer; 1 beat/cycle, all outputs registered.
// Define AXIS_SKID_SLICE_TLAST_EN to carry tlast through the slice and count completed frames.
module axis_skid_slice
   import axis_skid_slice_pkg::*;
#(
   parameter int DATA_WIDTH = 8
`ifdef AXIS_SKID_SLICE_TLAST_EN
  ,parameter int COUNT_WIDTH = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready
`ifdef AXIS_SKID_SLICE_TLAST_EN
  ,input  logic                   s_tlast,
   output logic                   m_tlast,
   output logic [COUNT_WIDTH-1:0] frame_count
`endif
);

`ifdef AXIS_SKID_SLICE_TLAST_EN
   localparam int PW = DATA_WIDTH + 1;
`else
   localparam int PW = DATA_WIDTH;
`endif

   slice_state_e state;
   slice_state_e state_next;
   logic [PW-1:0] out_q;
   logic [PW-1:0] skid_q;
   logic [PW-1:0] in_payload;
   logic in_beat;
   logic out_beat;

`ifdef AXIS_SKID_SLICE_TLAST_EN
   assign in_payload = {s_tlast, s_tdata};
   assign m_tlast    = out_q[DATA_WIDTH];
`else
   assign in_payload = s_tdata;
`endif
   assign m_tdata = out_q[DATA_WIDTH-1:0];

   // Handshakes only look at registered ready/valid, so neither direction has a combinational path.
   always_comb begin
      in_beat    = s_tvalid && s_tready;
      out_beat   = m_tvalid && m_tready;
      state_next = slice_next_state(state, in_beat, out_beat);
   end

   // Ready and valid are registered from the next state so they line up with the new occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_EMPTY;
         out_q    <= '0;
         skid_q   <= '0;
         m_tvalid <= 1'b0;
         s_tready <= 1'b0;
      end else begin
         state    <= state_next;
         m_tvalid <= (state_next != S_EMPTY);
         s_tready <= (state_next != S_FULL);
         case (state)
            S_EMPTY: begin
               if (in_beat) out_q <= in_payload;
            end
            S_BUSY: begin
               if (in_beat && out_beat)  out_q  <= in_payload;
               else if (in_beat)         skid_q <= in_payload;
            end
            S_FULL: begin
               if (out_beat) out_q <= skid_q;
            end
            default: ;
         endcase
      end
   end

`ifdef AXIS_SKID_SLICE_TLAST_EN
   // A frame counts as complete when its last beat leaves the slice; the count wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count <= '0;
      end else if (out_beat && out_q[DATA_WIDTH]) begin
         frame_count <= frame_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_skid_slice.sv
// Self-checking bench for axis_skid_slice: occupancy-queue model checked every cycle plus directed literals.
module tb_axis_skid_slice;

   localparam int DATA_WIDTH  = 8;
   localparam int COUNT_WIDTH = 16;

   typedef struct {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [DATA_WIDTH-1:0] s_tdata = '0;
   logic                  s_tvalid = 1'b0;
   logic                  s_tready;
   logic [DATA_WIDTH-1:0] m_tdata;
   logic                  m_tvalid;
   logic                  m_tready = 1'b0;
   logic                  s_tlast = 1'b0;
`ifdef AXIS_SKID_SLICE_TLAST_EN
   logic                   m_tlast;
   logic [COUNT_WIDTH-1:0] frame_count;
`endif

   int     checks = 0;
   int     errors = 0;
   longint cycle = 0;

   beat_t  modelQ[$];
   beat_t  outLog[$];
   longint outCycle[$];
   bit     started = 1'b0;
   bit     armed = 1'b0;
   int     modelFrames = 0;

   always #5 clk = ~clk;

   axis_skid_slice #(
      .DATA_WIDTH(DATA_WIDTH)
`ifdef AXIS_SKID_SLICE_TLAST_EN
     ,.COUNT_WIDTH(COUNT_WIDTH)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .s_tdata(s_tdata),
      .s_tvalid(s_tvalid),
      .s_tready(s_tready),
      .m_tdata(m_tdata),
      .m_tvalid(m_tvalid),
      .m_tready(m_tready)
`ifdef AXIS_SKID_SLICE_TLAST_EN
     ,.s_tlast(s_tlast),
      .m_tlast(m_tlast),
      .frame_count(frame_count)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // The slice is a FIFO of depth 2: valid means non-empty, ready means fewer than 2 held beats.
   always @(negedge clk) begin : compare
      beat_t b;
      bit    inBeat;
      bit    outBeat;
      cycle++;
      if (started) begin
         checkOutput("m_tvalid", m_tvalid, modelQ.size() > 0);
         checkOutput("s_tready", s_tready, armed && modelQ.size() < 2);
         if (modelQ.size() > 0 && m_tvalid === 1'b1) begin
            checkOutput("m_tdata", m_tdata, modelQ[0].data);
`ifdef AXIS_SKID_SLICE_TLAST_EN
            checkOutput("m_tlast", m_tlast, modelQ[0].last);
`endif
         end
`ifdef AXIS_SKID_SLICE_TLAST_EN
         checkOutput("frame_count", frame_count, modelFrames % (1 << COUNT_WIDTH));
`endif
      end
      if (rst) begin
         modelQ.delete();
         armed       = 1'b0;
         started     = 1'b1;
         modelFrames = 0;
      end else if (started) begin
         inBeat  = s_tvalid && armed && (modelQ.size() < 2);
         outBeat = m_tready && (modelQ.size() > 0);
         if (outBeat) begin
            b = modelQ.pop_front();
            outLog.push_back(b);
            outCycle.push_back(cycle);
            if (b.last) modelFrames++;
         end
         if (inBeat) begin
            b.data = s_tdata;
            b.last = s_tlast;
            modelQ.push_back(b);
         end
         armed = 1'b1;
      end
   end

   // Presents one beat and returns #1 after the edge that accepted it; s_tvalid is left high.
   task automatic applyStimulus(input logic [DATA_WIDTH-1:0] d, input logic l);
      bit acc;
      int n;
      n = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      do begin
         @(negedge clk);
         acc = s_tready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) begin
         checks++;
         errors++;
         $display("[TB] FAIL send_timeout: beat 0x%0h not accepted after %0d cycles, expected acceptance", d, n);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #1500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int base;
      int bad;
      int sent;
      longint c0;
      bit acc;
      logic [11:0] lastVec;

      // Reset held with upstream valid asserted.
      rst = 1'b1; s_tvalid = 1'b1; s_tdata = 8'hEE; m_tready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("reset_s_tready", s_tready, 1'b0);
      checkOutput("reset_m_tvalid", m_tvalid, 1'b0);
      checkOutput("reset_m_tdata", m_tdata, 8'h00);
`ifdef AXIS_SKID_SLICE_TLAST_EN
      checkOutput("reset_m_tlast", m_tlast, 1'b0);
      checkOutput("reset_frame_count", frame_count, 16'h0000);
`endif
      s_tvalid = 1'b0;
      rst = 1'b0;
      idleCycles(1);
      checkOutput("ready_after_reset", s_tready, 1'b1);

      // Single beat: one cycle latency, then back to empty.
      m_tready = 1'b1;
      base = outLog.size();
      applyStimulus(8'h5A, 1'b0);
      s_tvalid = 1'b0;
      checkOutput("single_m_tvalid", m_tvalid, 1'b1);
      checkOutput("single_m_tdata", m_tdata, 8'h5A);
      idleCycles(1);
      checkOutput("single_empty", m_tvalid, 1'b0);
      checkOutput("single_count", outLog.size() - base, 1);

      // Streaming 0x00..0xFF back to back.
      base = outLog.size();
      c0 = cycle;
      for (int i = 0; i < 256; i++) applyStimulus(i[7:0], 1'b0);
      checkOutput("stream_in_cycles", cycle - c0, 256);
      s_tvalid = 1'b0;
      idleCycles(3);
      checkOutput("stream_count", outLog.size() - base, 256);
      if (outLog.size() >= base + 256) begin
         bad = 0;
         for (int i = 0; i < 256; i++) if (outLog[base + i].data != i[7:0]) bad++;
         checkOutput("stream_order", bad, 0);
         checkOutput("stream_span", outCycle[base + 255] - outCycle[base], 255);
      end

      // Backpressure: two beats fill the slice, the third waits.
      m_tready = 1'b0;
      base = outLog.size();
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h22, 1'b0);
      checkOutput("bp_s_tready", s_tready, 1'b0);
      checkOutput("bp_m_tdata", m_tdata, 8'h11);
      s_tdata = 8'h33;
      idleCycles(3);
      checkOutput("bp_hold_ready", s_tready, 1'b0);
      checkOutput("bp_hold_data", m_tdata, 8'h11);
      checkOutput("bp_no_output", outLog.size() - base, 0);
      m_tready = 1'b1;
      applyStimulus(8'h33, 1'b0);
      s_tvalid = 1'b0;
      idleCycles(4);
      checkOutput("bp_count", outLog.size() - base, 3);
      if (outLog.size() >= base + 3) begin
         checkOutput("bp_out0", outLog[base].data, 8'h11);
         checkOutput("bp_out1", outLog[base + 1].data, 8'h22);
         checkOutput("bp_out2", outLog[base + 2].data, 8'h33);
      end

      // Random stalls on both sides; upstream holds each beat until accepted.
      base = outLog.size();
      sent = 0;
      c0 = cycle;
      s_tvalid = 1'b0;
      while (sent < 10000 && (cycle - c0) < 60000) begin
         @(negedge clk);
         acc = s_tvalid && s_tready;
         @(posedge clk);
         #1;
         if (acc) begin
            sent++;
            s_tvalid = 1'b0;
         end
         if (!s_tvalid && sent < 10000 && $urandom_range(1, 0) == 1) begin
            s_tvalid = 1'b1;
            s_tdata  = DATA_WIDTH'($urandom);
         end
         m_tready = ($urandom_range(1, 0) == 1);
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      idleCycles(5);
      checkOutput("random_sent", sent, 10000);
      checkOutput("random_out_count", outLog.size() - base, 10000);

      // Reset while full discards both buffered beats.
      m_tready = 1'b0;
      applyStimulus(8'hA1, 1'b0);
      applyStimulus(8'hA2, 1'b0);
      s_tvalid = 1'b0;
      checkOutput("full_before_reset", s_tready, 1'b0);
      rst = 1'b1;
      idleCycles(1);
      rst = 1'b0;
      checkOutput("mid_reset_m_tvalid", m_tvalid, 1'b0);
      base = outLog.size();
      m_tready = 1'b1;
      idleCycles(5);
      checkOutput("mid_reset_nothing_out", outLog.size() - base, 0);
      checkOutput("mid_reset_still_empty", m_tvalid, 1'b0);

      // Three 4-beat frames.
      base = outLog.size();
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < 4; k++)
            applyStimulus(8'h40 + 8'(f * 4 + k), k == 3);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      idleCycles(4);
      checkOutput("frames_count", outLog.size() - base, 12);
      if (outLog.size() >= base + 12) begin
         bad = 0;
         lastVec = '0;
         for (int i = 0; i < 12; i++) begin
            if (outLog[base + i].data != 8'h40 + 8'(i)) bad++;
            lastVec[i] = outLog[base + i].last;
         end
         checkOutput("frames_order", bad, 0);
`ifdef AXIS_SKID_SLICE_TLAST_EN
         checkOutput("frames_last_pos", lastVec, 12'h888);
`endif
      end
`ifdef AXIS_SKID_SLICE_TLAST_EN
      checkOutput("frames_frame_count", frame_count, 16'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
